fft_ctrl: RTL and testbench

FFT_CTRL -- requirements
Module: fft_ctrl

---
 rtl/fft_pkg.sv | 17 +
 rtl/fft_delay_line.sv | 41 ++++
 rtl/fft_ctrl.sv | 147 ++++++++++++++
 tb/tb_fft_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT address-generation controller.
//   fft_state_t     : controller FSM states
//   DEF_N_LOG2      : default log2 of the transform length
//   DEF_BF_LATENCY  : default butterfly pipeline latency in cycles
package fft_pkg;

  localparam int DEF_N_LOG2     = 4;
  localparam int DEF_BF_LATENCY = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } fft_state_t;

endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth register chain used to align the write-back strobe and
// addresses with the butterfly result.
//   clk_i  : clock
//   rst_ni : asynchronous active-low clear of every tap
//   din_i  : word entering the chain
//   dout_o : word delayed by exactly DEPTH cycles
module fft_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_tap
      logic [WIDTH-1:0] tap_in;
      logic [WIDTH-1:0] tap_reg;

      if (gi == 0) begin : g_first
        assign tap_in = din_i;
      end else begin : g_chain
        assign tap_in = g_tap[gi-1].tap_reg;
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          tap_reg <= '0;
        end else begin
          tap_reg <= tap_in;
        end
      end
    end
  endgenerate

  assign dout_o = g_tap[DEPTH-1].tap_reg;

endmodule

// File: rtl/fft_ctrl.sv
// In-place radix-2 FFT sequencer. Walks N_LOG2 stages of N/2 butterflies,
// emits operand read addresses and twiddle index, and replays the addresses
// PIPE cycles later as write-back addresses.
//   clk_i, rst_ni               : clock, asynchronous active-low reset
//   start_i                     : request a full transform (accepted in IDLE)
//   busy_o, done_o              : run in progress / one-cycle completion pulse
//   rd_en_o, rd_addr_a/b_o      : sample RAM read strobe and operand addresses
//   twid_idx_o                  : twiddle ROM index aligned with rd_en_o
//   wr_en_o, wr_addr_a/b_o      : write-back strobe and addresses
//   stage_o                     : current stage number
module fft_ctrl
  import fft_pkg::*;
#(
  parameter int N_LOG2     = DEF_N_LOG2,
  parameter int BF_LATENCY = DEF_BF_LATENCY
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         rd_en_o,
  output logic [N_LOG2-1:0]            rd_addr_a_o,
  output logic [N_LOG2-1:0]            rd_addr_b_o,
  output logic [N_LOG2-2:0]            twid_idx_o,
  output logic                         wr_en_o,
  output logic [N_LOG2-1:0]            wr_addr_a_o,
  output logic [N_LOG2-1:0]            wr_addr_b_o,
  output logic [$clog2(N_LOG2+1)-1:0]  stage_o
);

  localparam int PIPE    = 1 + BF_LATENCY;
  localparam int HALF_N  = 1 << (N_LOG2 - 1);
  localparam int K_W     = N_LOG2 - 1;
  localparam int STAGE_W = $clog2(N_LOG2 + 1);
  localparam int DCNT_W  = $clog2(PIPE + 1);
  localparam int DL_W    = 1 + 2 * N_LOG2;

  localparam logic [N_LOG2-1:0]  ADDR_ONE   = 1;
  localparam logic [K_W-1:0]     K_LAST     = K_W'(HALF_N - 1);
  localparam logic [DCNT_W-1:0]  DCNT_LAST  = DCNT_W'(PIPE - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(N_LOG2 - 1);

  fft_state_t         state_reg, state_next;
  logic [K_W-1:0]     k_reg, k_next;
  logic [STAGE_W-1:0] stage_reg, stage_next;
  logic [DCNT_W-1:0]  dcnt_reg, dcnt_next;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= ST_IDLE;
      k_reg     <= '0;
      stage_reg <= '0;
      dcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      stage_reg <= stage_next;
      dcnt_reg  <= dcnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    stage_next = stage_reg;
    dcnt_next  = dcnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_i) begin
          state_next = ST_RUN;
          k_next     = '0;
          stage_next = '0;
        end
      end
      ST_RUN: begin
        if (k_reg == K_LAST) begin
          state_next = ST_DRAIN;
          dcnt_next  = '0;
        end else begin
          k_next = k_reg + 1'b1;
        end
      end
      ST_DRAIN: begin
        // Hold off the next stage until the final write of this one is out.
        if (dcnt_reg == DCNT_LAST) begin
          if (stage_reg == STAGE_LAST) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_RUN;
            stage_next = stage_reg + 1'b1;
            k_next     = '0;
          end
        end else begin
          dcnt_next = dcnt_reg + 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        stage_next = '0;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Butterfly addressing: the stage-s span is 2*half, operands sit half apart.
  logic [N_LOG2-1:0] k_ext, half, pos, group, addr_a, addr_b, twid_full;
  logic              run_en;

  always_comb begin
    k_ext     = {1'b0, k_reg};
    half      = ADDR_ONE << stage_reg;
    pos       = k_ext & (half - ADDR_ONE);
    group     = k_ext >> stage_reg;
    addr_a    = ((group << stage_reg) << 1) | pos;
    addr_b    = addr_a | half;
    twid_full = pos << (STAGE_LAST - stage_reg);
    run_en    = (state_reg == ST_RUN);
  end

  assign rd_en_o     = run_en;
  assign rd_addr_a_o = run_en ? addr_a : '0;
  assign rd_addr_b_o = run_en ? addr_b : '0;
  assign twid_idx_o  = run_en ? twid_full[N_LOG2-2:0] : '0;
  assign busy_o      = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  assign done_o      = (state_reg == ST_DONE);
  assign stage_o     = stage_reg;

  logic [DL_W-1:0] dl_in, dl_out;

  assign dl_in = {rd_en_o, rd_addr_a_o, rd_addr_b_o};

  fft_delay_line #(
    .WIDTH(DL_W),
    .DEPTH(PIPE)
  ) u_wb_delay (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .din_i (dl_in),
    .dout_o(dl_out)
  );

  assign wr_en_o     = dl_out[DL_W-1];
  assign wr_addr_a_o = dl_out[2*N_LOG2-1:N_LOG2];
  assign wr_addr_b_o = dl_out[N_LOG2-1:0];

endmodule

// File: tb/tb_fft_ctrl.sv
module tb_fft_ctrl;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic start = 1'b0;
  logic sw_start = 1'b0;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main DUT: N_LOG2=4, BF_LATENCY=1 (PIPE=2)
  logic       busy, done, rd_en, wr_en;
  logic [3:0] ra, rb, wa, wb;
  logic [2:0] tw, stage;

  fft_ctrl #(.N_LOG2(4), .BF_LATENCY(1)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start),
    .busy_o(busy), .done_o(done),
    .rd_en_o(rd_en), .rd_addr_a_o(ra), .rd_addr_b_o(rb), .twid_idx_o(tw),
    .wr_en_o(wr_en), .wr_addr_a_o(wa), .wr_addr_b_o(wb), .stage_o(stage)
  );

  // Latency sweep instances, BF_LATENCY = 0..4
  logic       sw_busy[5], sw_done[5], sw_rd_en[5], sw_wr_en[5];
  logic [3:0] sw_ra[5], sw_rb[5], sw_wa[5], sw_wb[5];
  logic [2:0] sw_tw[5], sw_stage[5];

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_sw
      fft_ctrl #(.N_LOG2(4), .BF_LATENCY(gi)) u_sw (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(sw_start),
        .busy_o(sw_busy[gi]), .done_o(sw_done[gi]),
        .rd_en_o(sw_rd_en[gi]), .rd_addr_a_o(sw_ra[gi]), .rd_addr_b_o(sw_rb[gi]),
        .twid_idx_o(sw_tw[gi]),
        .wr_en_o(sw_wr_en[gi]), .wr_addr_a_o(sw_wa[gi]), .wr_addr_b_o(sw_wb[gi]),
        .stage_o(sw_stage[gi])
      );
    end
  endgenerate

  // Hand-computed butterfly operand A and twiddle index per stage / k
  localparam int EXP_A [4][8] = '{
    '{0, 2, 4, 6, 8, 10, 12, 14},
    '{0, 1, 4, 5, 8,  9, 12, 13},
    '{0, 1, 2, 3, 8,  9, 10, 11},
    '{0, 1, 2, 3, 4,  5,  6,  7}};
  localparam int EXP_TW [4][8] = '{
    '{0, 0, 0, 0, 0, 0, 0, 0},
    '{0, 4, 0, 4, 0, 4, 0, 4},
    '{0, 2, 4, 6, 0, 2, 4, 6},
    '{0, 1, 2, 3, 4, 5, 6, 7}};
  localparam int HALF [4] = '{1, 2, 4, 8};

  typedef struct {
    int cyc;
    int a;
    int b;
    int tw;
    int st;
  } ev_t;

  ev_t rdq[$];
  ev_t wrq[$];
  int  doneq[$];

  int busy_lo = 1;
  int busy_hi = 0;
  int req = 0;
  int sw_t0 = 0;

  int n_chk = 0;
  int n_fail = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int sw_last_wr[5] = '{-1, -1, -1, -1, -1};
  int sw_last_st[5] = '{-1, -1, -1, -1, -1};
  int sw_rd_n[5] = '{0, 0, 0, 0, 0};
  int sw_done_seen[5] = '{0, 0, 0, 0, 0};

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected transactions for one full run started (accepted) in cycle t0.
  task automatic push_run(input int t0);
    ev_t e;
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 8; k++) begin
        e.cyc = t0 + 1 + s * 10 + k;
        e.a   = EXP_A[s][k];
        e.b   = EXP_A[s][k] + HALF[s];
        e.tw  = EXP_TW[s][k];
        e.st  = s;
        rdq.push_back(e);
        e.cyc = e.cyc + 2;
        wrq.push_back(e);
      end
    end
    doneq.push_back(t0 + 41);
    busy_lo = t0 + 1;
    busy_hi = t0 + 40;
  endtask

  // Monitor: single owner of all comparisons.
  always @(negedge clk) begin
    ev_t e;
    int  dc;
    if (!rst_ni) begin
      chk("reset_outputs_zero",
          int'({busy, done, rd_en, wr_en, ra, rb, tw, wa, wb, stage}), 0);
    end else begin
      chk("busy", int'(busy), (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
      if (rd_en) begin
        rd_cnt++;
        if (rdq.size() == 0) begin
          chk("unexpected_read", 1, 0);
        end else begin
          e = rdq.pop_front();
          chk("rd_cycle", cyc, e.cyc);
          chk("rd_addr_a", int'(ra), e.a);
          chk("rd_addr_b", int'(rb), e.b);
          chk("twid_idx", int'(tw), e.tw);
          chk("stage", int'(stage), e.st);
        end
      end
      if (wr_en) begin
        wr_cnt++;
        if (wrq.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          e = wrq.pop_front();
          chk("wr_cycle", cyc, e.cyc);
          chk("wr_addr_a", int'(wa), e.a);
          chk("wr_addr_b", int'(wb), e.b);
        end
      end
      if (done) begin
        if (doneq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          dc = doneq.pop_front();
          chk("done_cycle", cyc, dc);
        end
      end
      for (int i = 0; i < 5; i++) begin
        if (sw_wr_en[i]) sw_last_wr[i] = cyc;
        if (sw_rd_en[i]) begin
          sw_rd_n[i]++;
          if (int'(sw_stage[i]) != sw_last_st[i]) begin
            if (sw_last_st[i] >= 0)
              chk($sformatf("sweep%0d_raw_gap", i), int'(cyc > sw_last_wr[i]), 1);
            sw_last_st[i] = int'(sw_stage[i]);
          end
        end
        if (sw_done[i]) begin
          sw_done_seen[i]++;
          chk($sformatf("sweep%0d_done_cycle", i), cyc, sw_t0 + 4 * (8 + i + 1) + 1);
          chk($sformatf("sweep%0d_last_write", i), sw_last_wr[i], sw_t0 + 4 * (8 + i + 1));
          chk($sformatf("sweep%0d_reads", i), sw_rd_n[i], 32);
        end
      end
    end
    if (req == 1) begin
      chk("read_strobes", rd_cnt, 32);
      chk("write_strobes", wr_cnt, 32);
    end
    if (req == 2) begin
      chk("reads_outstanding", rdq.size(), 0);
      chk("writes_outstanding", wrq.size(), 0);
      chk("done_outstanding", doneq.size(), 0);
      for (int i = 0; i < 5; i++)
        chk($sformatf("sweep%0d_done_seen", i), sw_done_seen[i], 1);
    end
  end

  task automatic goto(input int c);
    do begin
      @(posedge clk);
      #1;
    end while (cyc < c);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  int t0;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    goto(cyc + 2);

    // Run 1: plain full transform
    t0 = cyc;
    push_run(t0);
    pulse_start();
    goto(t0 + 45);
    req = 1;
    goto(t0 + 46);
    req = 0;

    // Run 2: extra start pulses while busy and while in DONE are ignored
    t0 = cyc;
    push_run(t0);
    pulse_start();
    goto(t0 + 15);
    pulse_start();
    goto(t0 + 41);
    pulse_start();
    goto(t0 + 50);

    // Run 3: reset in the middle; all pending traffic must vanish
    t0 = cyc;
    push_run(t0);
    pulse_start();
    goto(t0 + 20);
    rst_ni = 1'b0;
    rdq.delete();
    wrq.delete();
    doneq.delete();
    busy_hi = t0 + 19;
    goto(t0 + 22);
    rst_ni = 1'b1;
    goto(t0 + 35);

    // Run 4: clean full transform after reset
    t0 = cyc;
    push_run(t0);
    pulse_start();
    goto(t0 + 45);

    // Latency sweep
    sw_t0 = cyc;
    sw_start = 1'b1;
    @(posedge clk);
    #1 sw_start = 1'b0;
    goto(sw_t0 + 60);

    req = 2;
    goto(cyc + 1);
    req = 0;
    goto(cyc + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
